// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a word-wide data memory port.
// Accepts one request at a time, builds byte strobes and lane-aligned store
// data, issues one or two word commands (two when the access straddles a word
// boundary) and returns sign/zero-extended load data with a one-cycle pulse.
module lsu_ctrl #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_WAIT0  = 3'd2,
        S_ISSUE1 = 3'd3,
        S_WAIT1  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t      state_reg, state_next;

    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [7:0]  m8_reg;
    logic        mis_reg;
    logic [31:0] rd0_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;

    // ---------------- request decode (combinational, from the live request)
    logic [3:0]  req_mask;
    logic [7:0]  req_m8;
    logic        req_mis;
    logic        req_illegal;
    logic        req_err;

    always_comb begin
        unique case (req_funct3[1:0])
            2'd0:    req_mask = 4'b0001;
            2'd1:    req_mask = 4'b0011;
            default: req_mask = 4'b1111;
        endcase
    end

    assign req_m8  = {4'b0000, req_mask} << req_addr[1:0];
    assign req_mis = |req_m8[7:4];
    // Loads allow B/H/W/BU/HU; stores only B/H/W.
    assign req_illegal = (req_funct3[1:0] == 2'd3) || (req_funct3 == 3'd6) ||
                         (req_we && req_funct3[2]);
    assign req_err = req_illegal || (req_mis && !SPLIT_EN);

    // ---------------- store data lane alignment
    // Shifting into a 64-bit window gives the first word in the low half and
    // the spill-over bytes for the second word in the high half.
    logic [63:0] wdata_wide;
    logic [31:0] mem_base;

    assign wdata_wide = {32'd0, wdata_reg} << {addr_reg[1:0], 3'b000};
    assign mem_base   = {addr_reg[31:2], 2'b00};

    // ---------------- load data merge and extension
    logic [63:0] rd_merged;
    logic [31:0] rd_shifted;
    logic [31:0] rd_ext;

    assign rd_merged = (state_reg == S_WAIT1) ? {mem_rdata, rd0_reg} : {32'd0, mem_rdata};

    // Pick result byte gi from merged byte (gi + offset).
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
        assign rd_shifted[8*gi +: 8] = rd_merged[(8*gi + 8*int'(addr_reg[1:0])) +: 8];
    end

    // Extend the aligned load data according to the latched access type.
    always_comb begin
        rd_ext = rd_shifted;
        unique case (funct3_reg)
            3'd0:    rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'd1:    rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'd4:    rd_ext = {24'd0, rd_shifted[7:0]};
            3'd5:    rd_ext = {16'd0, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; memory responses outside the WAIT states are ignored.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:   if (req_valid)  state_next = req_err ? S_RESP : S_ISSUE0;
            S_ISSUE0: if (mem_ready)  state_next = S_WAIT0;
            S_WAIT0:  if (mem_rvalid) state_next = mis_reg ? S_ISSUE1 : S_RESP;
            S_ISSUE1: if (mem_ready)  state_next = S_WAIT1;
            S_WAIT1:  if (mem_rvalid) state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; command fields come from latched request
    // registers so they stay stable while the memory stalls.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_valid  = 1'b0;
        mem_addr   = 32'd0;
        mem_we     = 1'b0;
        mem_wstrb  = 4'd0;
        mem_wdata  = 32'd0;
        unique case (state_reg)
            S_IDLE: req_ready = 1'b1;
            S_ISSUE0: begin
                mem_valid = 1'b1;
                mem_addr  = mem_base;
                mem_we    = we_reg;
                mem_wstrb = we_reg ? m8_reg[3:0] : 4'd0;
                mem_wdata = wdata_wide[31:0];
            end
            S_ISSUE1: begin
                mem_valid = 1'b1;
                mem_addr  = mem_base + 32'd4;
                mem_we    = we_reg;
                mem_wstrb = we_reg ? m8_reg[7:4] : 4'd0;
                mem_wdata = wdata_wide[63:32];
            end
            S_RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

    // Request latch, first-word capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg         <= 1'b0;
            funct3_reg     <= 3'd0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            m8_reg         <= 8'd0;
            mis_reg        <= 1'b0;
            rd0_reg        <= 32'd0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        we_reg     <= req_we;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        m8_reg     <= req_m8;
                        mis_reg    <= req_mis;
                        rd0_reg    <= 32'd0;
                        if (req_err) begin
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'd0;
                        end
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid) begin
                        rd0_reg <= mem_rdata;
                        if (!mis_reg) begin
                            resp_err_reg   <= 1'b0;
                            resp_rdata_reg <= we_reg ? 32'd0 : rd_ext;
                        end
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid) begin
                        resp_err_reg   <= 1'b0;
                        resp_rdata_reg <= we_reg ? 32'd0 : rd_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
